pipe_stage_reg: RTL

Parametrised pipeline-stage register for inter-stage buses (IF/ID, ID/EX, EX/MEM, MEM/WB). It replaces the fixed-width, single-entry stage registers and keeps the same "previous stage over / next stage allow-in" handshake. It adds flush, an optional two-entry skid mode that removes the combinational allow-in path between stages, occupancy reporting, and a saturating back-pressure counter.

---
 rtl/pipe_stage_reg.sv | 112 +++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised inter-stage pipeline register with a valid /
// allow-in handshake, flush, optional two-entry skid buffer (registered
// allow-in), occupancy reporting and a saturating back-pressure counter.
module pipe_stage_reg #(
  parameter int WIDTH = 32,
  parameter int SKID  = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             up_valid_i,
  input  logic [WIDTH-1:0] up_bus_i,
  output logic             up_allow_in_o,
  output logic             down_valid_o,
  output logic [WIDTH-1:0] down_bus_o,
  input  logic             down_allow_in_i,
  output logic [1:0]       occupancy_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] main_q;
  logic             main_v;
  logic             skid_v_w;
  logic             in_fire;
  logic             out_fire;
  logic [CNT_W-1:0] stall_cnt_q;

  assign out_fire = main_v && down_allow_in_i;
  assign in_fire  = up_valid_i && up_allow_in_o;

  generate
    if (SKID == 0) begin : g_single
      // Single entry: allow-in passes straight through from the consumer.
      assign up_allow_in_o = !main_v || down_allow_in_i;
      assign skid_v_w      = 1'b0;

      // Main entry: load on accept, empty on issue without refill.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          main_q <= '0;
          main_v <= 1'b0;
        end else if (flush_i) begin
          main_v <= 1'b0;
        end else if (in_fire) begin
          main_q <= up_bus_i;
          main_v <= 1'b1;
        end else if (out_fire) begin
          main_v <= 1'b0;
        end
      end
    end else begin : g_skid
      logic [WIDTH-1:0] skid_q;
      logic             skid_v;
      logic             main_free;

      // Allow-in depends only on a flop, breaking the inter-stage comb path.
      assign up_allow_in_o = !skid_v;
      assign skid_v_w      = skid_v;
      assign main_free     = !main_v || out_fire;

      // Main/skid pair: skid always drains into main first to keep FIFO order.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          main_q <= '0;
          main_v <= 1'b0;
          skid_q <= '0;
          skid_v <= 1'b0;
        end else if (flush_i) begin
          main_v <= 1'b0;
          skid_v <= 1'b0;
        end else if (main_free) begin
          if (skid_v) begin
            main_q <= skid_q;
            main_v <= 1'b1;
            if (in_fire) begin
              skid_q <= up_bus_i;
            end else begin
              skid_v <= 1'b0;
            end
          end else if (in_fire) begin
            main_q <= up_bus_i;
            main_v <= 1'b1;
          end else begin
            main_v <= 1'b0;
          end
        end else if (in_fire) begin
          // Main is stalled and skid is empty: park the extra payload.
          skid_q <= up_bus_i;
          skid_v <= 1'b1;
        end
      end
    end
  endgenerate

  // Count stalled edges (valid held, consumer refusing); saturate, reset-only clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else if (main_v && !down_allow_in_i && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign down_valid_o = main_v;
  assign down_bus_o   = main_q;
  assign occupancy_o  = {1'b0, main_v} + {1'b0, skid_v_w};
  assign stall_cnt_o  = stall_cnt_q;

endmodule
